// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-command sequencer: sends a command (plus optional argument), waits for
// the 0xFA acknowledge with resend retries and a response timeout, and forwards scan codes.
module ps2_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       scan_valid,
    output logic [7:0] scan_data,
    output logic       cmd_done,
    output logic       cmd_err
);

    localparam int unsigned   TW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_PRE      = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [7:0]    RSP_ACK     = 8'hFA;
    localparam logic [7:0]    RSP_RESEND  = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_CMD,
        SEND_ARG,
        WAIT_ARG,
        FINISH
    } state_t;

    state_t        state;
    logic [7:0]    cmd_q;
    logic [7:0]    arg_q;
    logic          has_arg_q;
    logic [3:0]    retry_cnt;
    logic [TW-1:0] to_cnt;

    logic in_wait;
    logic got_ack;
    logic got_resend;
    logic consume;
    logic timed_out;

    always_comb begin
        cmd_ready  = (state == IDLE);
        in_wait    = (state == WAIT_CMD) || (state == WAIT_ARG);
        got_ack    = in_wait && rx_valid && (rx_data == RSP_ACK);
        got_resend = in_wait && rx_valid && (rx_data == RSP_RESEND);
        consume    = got_ack || got_resend;
        // The counter's next value hitting the terminal count puts FINISH exactly
        // TIMEOUT_CYCLES cycles after the handshake cycle.
        timed_out  = (to_cnt >= TO_PRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_q      <= '0;
            arg_q      <= '0;
            has_arg_q  <= 1'b0;
            retry_cnt  <= '0;
            to_cnt     <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
            cmd_done   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_done   <= 1'b0;
            scan_valid <= rx_valid && !consume;
            if (rx_valid && !consume) begin
                scan_data <= rx_data;
            end
            if (in_wait && !consume && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q     <= cmd_byte;
                        arg_q     <= cmd_arg;
                        has_arg_q <= cmd_has_arg;
                        retry_cnt <= '0;
                        tx_valid  <= 1'b1;
                        tx_data   <= cmd_byte;
                        state     <= SEND_CMD;
                    end
                end
                SEND_CMD, SEND_ARG: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        to_cnt   <= '0;
                        state    <= (state == SEND_CMD) ? WAIT_CMD : WAIT_ARG;
                    end
                end
                WAIT_CMD, WAIT_ARG: begin
                    if (got_ack) begin
                        retry_cnt <= '0;
                        if ((state == WAIT_CMD) && has_arg_q) begin
                            tx_valid <= 1'b1;
                            tx_data  <= arg_q;
                            state    <= SEND_ARG;
                        end else begin
                            cmd_done <= 1'b1;
                            cmd_err  <= 1'b0;
                            state    <= FINISH;
                        end
                    end else if (got_resend) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            tx_valid  <= 1'b1;
                            tx_data   <= (state == WAIT_CMD) ? cmd_q : arg_q;
                            state     <= (state == WAIT_CMD) ? SEND_CMD : SEND_ARG;
                        end else begin
                            cmd_done <= 1'b1;
                            cmd_err  <= 1'b1;
                            state    <= FINISH;
                        end
                    end else if (timed_out) begin
                        cmd_done <= 1'b1;
                        cmd_err  <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: command/argument sequencing, resend retries,
// response timeout, scan-code forwarding and mid-command reset.
module tb_ps2_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       cmd_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       cmd_done;
    logic       cmd_err;

    int errors = 0;
    int checks = 0;

    int         tx_cnt   = 0;
    int         done_cnt = 0;
    int         scan_cnt = 0;
    logic [7:0] tx_hist [0:63];

    int base;
    int d0;
    int s0;

    ps2_cmd_sequencer #(
        .TIMEOUT_CYCLES(16),
        .MAX_RETRY     (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .cmd_has_arg(cmd_has_arg),
        .cmd_arg    (cmd_arg),
        .cmd_ready  (cmd_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    // Activity log taken at the active edge from pre-edge output values.
    always @(posedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            tx_hist[tx_cnt % 64] <= tx_data;
            tx_cnt <= tx_cnt + 1;
        end
        if (cmd_done)   done_cnt <= done_cnt + 1;
        if (scan_valid) scan_cnt <= scan_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cyc();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic issue(input logic [7:0] b, input logic has, input logic [7:0] a);
        cmd_valid   = 1'b1;
        cmd_byte    = b;
        cmd_has_arg = has;
        cmd_arg     = a;
        cyc();
        cmd_valid   = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_byte    = 8'h00;
        cmd_has_arg = 1'b0;
        cmd_arg     = 8'h00;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        repeat (3) cyc();

        chk("rst_ready",     32'(cmd_ready),  32'd1);
        chk("rst_tx_valid",  32'(tx_valid),   32'd0);
        chk("rst_tx_data",   32'(tx_data),    32'h00);
        chk("rst_scan_vld",  32'(scan_valid), 32'd0);
        chk("rst_scan_data", 32'(scan_data),  32'h00);
        chk("rst_done",      32'(cmd_done),   32'd0);
        chk("rst_err",       32'(cmd_err),    32'd0);
        rst_n = 1'b1;
        cyc();

        // ED + 07, acknowledged after each byte
        base = tx_cnt; d0 = done_cnt; s0 = scan_cnt;
        tx_ready = 1'b1;
        issue(8'hED, 1'b1, 8'h07);
        chk("t1_txv",      32'(tx_valid),  32'd1);
        chk("t1_txd",      32'(tx_data),   32'hED);
        chk("t1_busy",     32'(cmd_ready), 32'd0);
        cyc();
        chk("t1_wait_txv", 32'(tx_valid),  32'd0);
        pulse_rx(8'hFA);
        chk("t1_arg_txv",  32'(tx_valid),  32'd1);
        chk("t1_arg_txd",  32'(tx_data),   32'h07);
        cyc();
        pulse_rx(8'hFA);
        chk("t1_done",     32'(cmd_done),  32'd1);
        chk("t1_err",      32'(cmd_err),   32'd0);
        cyc();
        chk("t1_ready",    32'(cmd_ready), 32'd1);
        chk("t1_done_clr", 32'(cmd_done),  32'd0);
        chk("t1_ntx",      32'(tx_cnt - base),            32'd2);
        chk("t1_tx0",      32'(tx_hist[base % 64]),       32'hED);
        chk("t1_tx1",      32'(tx_hist[(base + 1) % 64]), 32'h07);
        chk("t1_nscan",    32'(scan_cnt - s0),            32'd0);
        chk("t1_ndone",    32'(done_cnt - d0),            32'd1);

        // FF, two resends then acknowledge
        base = tx_cnt;
        issue(8'hFF, 1'b0, 8'h00);
        cyc();
        pulse_rx(8'hFE);
        chk("t2_re1_txv", 32'(tx_valid), 32'd1);
        chk("t2_re1_txd", 32'(tx_data),  32'hFF);
        cyc();
        pulse_rx(8'hFE);
        chk("t2_re2_txd", 32'(tx_data),  32'hFF);
        cyc();
        pulse_rx(8'hFA);
        chk("t2_done",    32'(cmd_done), 32'd1);
        chk("t2_err",     32'(cmd_err),  32'd0);
        chk("t2_ntx",     32'(tx_cnt - base), 32'd3);
        chk("t2_tx2",     32'(tx_hist[(base + 2) % 64]), 32'hFF);
        cyc();

        // F4, four resends exhaust MAX_RETRY=3
        base = tx_cnt;
        issue(8'hF4, 1'b0, 8'h00);
        cyc();
        repeat (3) begin
            pulse_rx(8'hFE);
            cyc();
        end
        chk("t3_busy", 32'(cmd_done), 32'd0);
        pulse_rx(8'hFE);
        chk("t3_done", 32'(cmd_done), 32'd1);
        chk("t3_err",  32'(cmd_err),  32'd1);
        chk("t3_ntx",  32'(tx_cnt - base), 32'd4);
        chk("t3_tx3",  32'(tx_hist[(base + 3) % 64]), 32'hF4);
        cyc();

        // EE, no response: FINISH 16 cycles after the handshake cycle
        issue(8'hEE, 1'b0, 8'h00);
        repeat (15) cyc();
        chk("t4_early", 32'(cmd_done), 32'd0);
        cyc();
        chk("t4_done",  32'(cmd_done), 32'd1);
        chk("t4_err",   32'(cmd_err),  32'd1);
        cyc();
        chk("t4_ready", 32'(cmd_ready), 32'd1);

        // Forwarding: rx in SEND forwarded, 1C in WAIT forwarded, FA in WAIT consumed, FA in IDLE forwarded
        s0 = scan_cnt;
        tx_ready = 1'b0;
        issue(8'hF3, 1'b0, 8'h00);
        pulse_rx(8'hFE);
        chk("t5_send_scv", 32'(scan_valid), 32'd1);
        chk("t5_send_scd", 32'(scan_data),  32'hFE);
        chk("t5_hold_txv", 32'(tx_valid),   32'd1);
        chk("t5_hold_txd", 32'(tx_data),    32'hF3);
        tx_ready = 1'b1;
        cyc();
        pulse_rx(8'h1C);
        chk("t5_1c_scv",   32'(scan_valid), 32'd1);
        chk("t5_1c_scd",   32'(scan_data),  32'h1C);
        chk("t5_1c_busy",  32'(cmd_done),   32'd0);
        pulse_rx(8'hFA);
        chk("t5_fa_scv",   32'(scan_valid), 32'd0);
        chk("t5_done",     32'(cmd_done),   32'd1);
        chk("t5_err",      32'(cmd_err),    32'd0);
        cyc();
        pulse_rx(8'hFA);
        chk("t5_idle_scv", 32'(scan_valid), 32'd1);
        chk("t5_idle_scd", 32'(scan_data),  32'hFA);
        cyc();
        chk("t5_scv_clr",  32'(scan_valid), 32'd0);
        chk("t5_nscan",    32'(scan_cnt - s0), 32'd3);

        // Reset during WAIT_ARG, then during SEND_CMD with tx_valid high
        d0 = done_cnt;
        issue(8'hED, 1'b1, 8'h02);
        cyc();
        pulse_rx(8'hFA);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_txv",   32'(tx_valid),  32'd0);
        chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rst_done",  32'(cmd_done),  32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        tx_ready = 1'b0;
        issue(8'hF2, 1'b0, 8'h00);
        chk("t6_pre_txv",   32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_drop_txv",  32'(tx_valid), 32'd0);
        chk("t6_drop_txd",  32'(tx_data),  32'h00);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_ndone",     32'(done_cnt - d0), 32'd0);

        base = tx_cnt;
        tx_ready = 1'b1;
        issue(8'hED, 1'b1, 8'h05);
        cyc();
        pulse_rx(8'hFA);
        chk("t6_arg_txd", 32'(tx_data), 32'h05);
        cyc();
        pulse_rx(8'hFA);
        chk("t6_done",    32'(cmd_done), 32'd1);
        chk("t6_err",     32'(cmd_err),  32'd0);
        chk("t6_ntx",     32'(tx_cnt - base), 32'd2);
        cyc();
        chk("t6_ready",   32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
